cgra_input_stream_dma: RTL

- Per-input-node read DMA channel that sits directly downstream of the DMA configuration CSR block.
- Consumes one channel's base address, size and stride plus the start-execution strobe.
- Issues strided 32-bit word reads on an OBI-style memory port, buffers returned words in a local FIFO, and streams them to one CGRA input node over a valid/ready handshake.
- Reports a sticky done level for status readback.

---
 rtl/cgra_input_stream_dma.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/cgra_input_stream_dma.sv
// Strided read DMA channel feeding one CGRA input node. It issues OBI-style word reads,
// buffers responses in a small FIFO and streams them out over valid/ready.
module cgra_input_stream_dma #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [15:0]           size_i,
    input  logic [15:0]           stride_i,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW:0] DepthLim = (CntW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           size_q, size_d;
    logic [15:0]           stride_q, stride_d;
    logic [15:0]           req_cnt_q, req_cnt_d;
    logic [15:0]           del_cnt_q, del_cnt_d;
    logic [CntW-1:0]       outst_q, outst_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [PtrW-1:0]       wptr_q, wptr_d;
    logic [PtrW-1:0]       rptr_q, rptr_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];

    logic [CntW:0]         credit_used;
    logic                  req, grant, rsp, push, pop;

    // A pop in this cycle already frees a slot, which keeps one word per cycle at depth 2.
    always_comb begin
        pop         = (count_q != '0) && ready_i;
        credit_used = {1'b0, outst_q} + {1'b0, count_q} - (CntW + 1)'(pop);
        req         = (state_q == StRun) && (req_cnt_q < size_q) && (credit_used < DepthLim);
        grant       = req && mem_gnt_i;
        rsp         = mem_rvalid_i && (state_q != StIdle) && (outst_q != '0);
        push        = rsp && (state_q == StRun);
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        stride_d  = stride_q;
        req_cnt_d = req_cnt_q;
        del_cnt_d = del_cnt_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        done_d    = done_q;
        outst_d   = outst_q + CntW'(grant) - CntW'(rsp);
        count_d   = count_q + CntW'(push) - CntW'(pop);

        if (grant) begin
            req_cnt_d = req_cnt_q + 16'd1;
            addr_d    = addr_q + ADDR_WIDTH'(stride_q);
        end
        if (push) wptr_d = wptr_q + PtrW'(1);
        if (pop) begin
            rptr_d    = rptr_q + PtrW'(1);
            del_cnt_d = del_cnt_q + 16'd1;
        end
        if (abort_i) done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i && !abort_i) begin
                    if (size_i == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d    = base_addr_i;
                        size_d    = size_i;
                        stride_d  = stride_i;
                        req_cnt_d = 16'd0;
                        del_cnt_d = 16'd0;
                        done_d    = 1'b0;
                        state_d   = StRun;
                    end
                end
            end
            StRun: begin
                if (abort_i) begin
                    count_d = '0;
                    wptr_d  = '0;
                    rptr_d  = '0;
                    state_d = (outst_d != '0) ? StFlush : StIdle;
                end else if (pop && (del_cnt_d == size_q)) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            StFlush: begin
                if (outst_d == '0) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            size_q    <= '0;
            stride_q  <= '0;
            req_cnt_q <= '0;
            del_cnt_q <= '0;
            outst_q   <= '0;
            count_q   <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            stride_q  <= stride_d;
            req_cnt_q <= req_cnt_d;
            del_cnt_q <= del_cnt_d;
            outst_q   <= outst_d;
            count_q   <= count_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            done_q    <= done_d;
        end
    end

    // Storage needs no reset: data_o is gated by the occupancy count.
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wptr_q] <= mem_rdata_i;
    end

    assign mem_req_o  = req;
    assign mem_addr_o = addr_q;
    assign valid_o    = (count_q != '0);
    assign data_o     = valid_o ? fifo_q[rptr_q] : '0;
    assign busy_o     = (state_q != StIdle);
    assign done_o     = done_q;

endmodule
